fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Decoupled instruction-fetch front end for the pipelined RV32I core.
//  Keeps the fetch PC, issues requests to an instruction memory of variable
//  latency, buffers returned instructions in a DEPTH-entry FIFO, and presents
//  them to decode through a valid/ready handshake.
//  On a redirect (taken branch or jump from execute), it flushes the FIFO and
//  discards responses still in flight.
// PARAMETERS
//  XLEN        32            address/instruction width
//  DEPTH       4             FIFO entries; also the credit limit (power of 2, >=2)
//  PC_START    32'h01000000  PC loaded at reset
//  INST_BYTES  4             sequential PC increment
//  ALIGN_MASK  32'hfffffffe  AND-mask applied to redirect_pc
// PORTS
//  clock          in   1     clock, rising edge
//  reset          in   1     synchronous, active-high
//  redirect_valid in   1     execute requests a PC change this cycle
//  redirect_pc    in   XLEN  target PC (masked internally)
//  imem_req_valid out  1     fetch request valid
//  imem_req_addr  out  XLEN  fetch address (current PC)
//  imem_req_ready in   1     imem accepts the request this cycle
//  imem_rsp_valid in   1     response valid; responses return in request order
//  imem_rsp_inst  in   XLEN  returned instruction
//  dec_valid      out  1     FIFO head is valid for decode
//  dec_pc         out  XLEN  PC of the head instruction
//  dec_inst       out  XLEN  head instruction
//  dec_ready      in   1     decode consumes the head (deasserted = stall)
//  occupancy      out  clog2(DEPTH+1)  current FIFO count (debug/perf)
// BEHAVIOUR
//  Reset: pc_q=PC_START. FIFO empty. outstanding=0. drop_cnt=0.
//   Outputs: imem_req_valid=0, dec_valid=0, occupancy=0.
//  Credits: imem_req_valid = !redirect_valid && (occupancy+outstanding < DEPTH).
//   A push can never overflow the FIFO.
//  Request fire = imem_req_valid && imem_req_ready:
//   - pc_q <= pc_q+INST_BYTES; outstanding++.
//   - imem_req_addr = pc_q, held stable while valid && !ready.
//  Response (imem_rsp_valid):
//   - drop_cnt>0: discard; drop_cnt--; outstanding--.
//   - drop_cnt==0: push {pc, inst}; outstanding--.
//   - The push PC comes from a PC-tag FIFO written at request fire.
//     It is part of the same storage sub-module.
//  Pop: dec_valid && dec_ready; occurs next edge. Push and pop in the same
//   cycle are legal at any occupancy, including full and empty.
//  Latency: request fire at cycle t, response at t+L, dec_valid at t+L+1.
//   There is no bypass from the response to decode.
//  Redirect (priority over everything else):
//   - pc_q <= redirect_pc & ALIGN_MASK. FIFO cleared (occupancy=0).
//   - No request is issued in the redirect cycle.
//   - dec_valid is forced 0 in that cycle; a dec_ready handshake is ignored.
//   - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0).
//   - A response arriving in the redirect cycle is discarded.
//   - Redirect while drop_cnt>0: recompute drop_cnt by the same rule.
//     outstanding tracks all in-flight requests including ones to be dropped.
//   - A first request to the new PC is issued the cycle after redirect.
//  Back-to-back redirects: the last one wins; each recomputes drop_cnt.
//  Reset mid-operation: all state returns to reset values next edge.
//   Responses to pre-reset requests must not arrive after reset (imem contract).
//  Width rules: pc_q wraps modulo 2^XLEN. Counters use clog2(DEPTH+1) bits.
//   Pointers use clog2(DEPTH) bits and wrap naturally.
// STRUCTURE
//  fetch_pkg holds PC_START, INST_BYTES, ALIGN_MASK, NOP (32'h00000013) and
//   the fetch_entry_t {pc, inst} typedef; shared with the decode and control blocks.
//  Sub-module fetch_fifo: parametrised synchronous FIFO for fetch_entry_t.
//   It has push, pop, flush, occupancy, head outputs, and a PC-tag side queue.
//  The top level holds pc_q, the credit logic, outstanding/drop_cnt, and redirect.
// TESTING
//  1. Reset, imem ready with L=1, dec_ready=1.
//     -> req addrs 0x01000000, 0x01000004, ... on consecutive cycles.
//     -> dec_valid first high 2 cycles after the first fire; PCs in order.
//  2. dec_ready=0 with DEPTH=4.
//     -> at most 4 requests issued; imem_req_valid drops; occupancy=4.
//     -> dec_ready=1 for 1 cycle: exactly one pop, then one new request.
//  3. L=3 with 3 in flight, then redirect_pc=0x01000103.
//     -> next req addr 0x01000102; the 3 old responses are discarded.
//     -> first dec_pc after redirect is 0x01000102.
//  4. Redirect in the same cycle as imem_rsp_valid with 2 outstanding.
//     -> drop_cnt=1; that response and the next are dropped; FIFO empty.
//  5. Full FIFO with simultaneous push and pop.
//     -> occupancy stays 4; no loss; order preserved (scoreboard check).
//  6. Assert reset mid-stream with 2 queued and 1 in flight.
//     -> next cycle: occupancy=0, dec_valid=0, req addr 0x01000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset PC, PC stepping/alignment constants,
// the canonical NOP encoding and the {pc, inst} entry handed to decode.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_START   = 32'h0100_0000;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hffff_fffe;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the imem response port and decode.
// Two queues share this block:
//  - a data queue of fetch_entry_t presented to decode (flushable);
//  - a PC-tag queue written at request time and popped on every response,
//    so each returning instruction is paired with the PC that fetched it.
//    The tag queue is never flushed by a redirect: responses that are going
//    to be dropped still have to consume their tag.
// Head is read combinationally so a pushed entry is visible on the next cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [XLEN-1:0]              push_inst,
    input  logic                         pop,
    input  logic                         tag_push,
    input  logic [XLEN-1:0]              tag_pc,
    input  logic                         tag_pop,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output fetch_entry_t                 head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t    entry_mem [DEPTH];
    logic [XLEN-1:0] tag_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] tag_wr_ptr_reg;
    logic [PW-1:0] tag_rd_ptr_reg;

    logic         pop_ok;
    logic         push_ok;
    fetch_entry_t push_entry;

    // A pop on an empty queue is a no-op; a push into a full queue is only
    // accepted when a pop frees the slot in the same cycle.
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg != FULL_COUNT) || pop_ok);

    // The entry's PC is the oldest outstanding request tag.
    assign push_entry.pc   = tag_mem[tag_rd_ptr_reg];
    assign push_entry.inst = push_inst;

    assign occupancy = count_reg;
    assign head      = entry_mem[rd_ptr_reg];

    // Data queue storage write (no reset: contents are qualified by count).
    always_ff @(posedge clock) begin
        if (!reset && !flush && push_ok) begin
            entry_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Data queue pointers and count; flush empties the queue in one edge.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Tag storage write at request fire.
    always_ff @(posedge clock) begin
        if (!reset && tag_push) begin
            tag_mem[tag_wr_ptr_reg] <= tag_pc;
        end
    end

    // Tag pointers: one tag per in-flight request, retired by its response.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr_reg <= tag_wr_ptr_reg + PW'(1);
            end
            if (tag_pop) begin
                tag_rd_ptr_reg <= tag_rd_ptr_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, throttles imem requests with
// a credit scheme (queued + in-flight never exceeds DEPTH, so a response can
// always be buffered), and handles redirects by flushing the queue and
// counting how many in-flight responses must be thrown away.
module fetch_queue #(
    parameter int                  XLEN       = fetch_pkg::XLEN,
    parameter int                  DEPTH      = 4,
    parameter logic [XLEN-1:0]     PC_START   = fetch_pkg::PC_START,
    parameter logic [XLEN-1:0]     INST_BYTES = fetch_pkg::INST_BYTES,
    parameter logic [XLEN-1:0]     ALIGN_MASK = fetch_pkg::ALIGN_MASK
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         imem_req_valid,
    output logic [XLEN-1:0]              imem_req_addr,
    input  logic                         imem_req_ready,
    input  logic                         imem_rsp_valid,
    input  logic [XLEN-1:0]              imem_rsp_inst,
    output logic                         dec_valid,
    output logic [XLEN-1:0]              dec_pc,
    output logic [XLEN-1:0]              dec_inst,
    input  logic                         dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   drop_cnt_next;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    logic [CW:0]     credits_used;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_keep;
    logic            dec_fire;

    // Every queued entry and every in-flight request holds one credit.
    assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign credit_ok    = credits_used < CREDIT_LIMIT;

    // No request and no decode handshake during reset or a redirect cycle.
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_valid = !reset && !redirect_valid && (fifo_count != '0);
    assign dec_pc    = fifo_head.pc;
    assign dec_inst  = fifo_head.inst;
    assign dec_fire  = dec_valid && dec_ready;
    assign occupancy = fifo_count;

    // Responses belonging to a stale PC stream, or arriving during a
    // redirect, are discarded instead of buffered.
    assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;

    // Next-state for PC, in-flight count and drop count.
    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_next    = drop_cnt_reg;
        if (redirect_valid) begin
            pc_next       = redirect_pc & ALIGN_MASK;
            // Everything still in flight after this cycle belongs to the
            // old stream; a response this cycle is already being discarded.
            drop_cnt_next = outstanding_reg - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + INST_BYTES;
            end
            if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
        end
    end

    // Fetch control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg          <= PC_START;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_inst (imem_rsp_inst),
        .pop       (dec_fire),
        .tag_push  (req_fire),
        .tag_pc    (pc_reg),
        .tag_pop   (imem_rsp_valid),
        .occupancy (fifo_count),
        .head      (fifo_head)
    );

endmodule
